pc_gen_unit: RTL and testbench

Parametrised program-counter generator for the fetch stage, succeeding the combinational next-PC select. It owns the PC register and a post-reset boot hold, and selects among sequential, branch, JAL and JALR targets. It adds stall, misaligned-target trapping and trap return. It drives the instruction-memory address and the pc/pc_plus4 values consumed by decode and execute.

---
 rtl/pc_gen_unit.sv | 114 +++++++++++
 tb/tb_pc_gen_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch-stage program-counter generator with boot hold, stall and misaligned-target trap (optional: PC_MISALIGN_TRAP_EN)
module pc_gen_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int              BOOT_DELAY   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jal_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic            trap_return,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_valid,
   output logic            misalign,
   output logic [XLEN-1:0] epc
);

   // Counter holds 0..BOOT_DELAY; the unit leaves BOOT on the edge where it reads BOOT_DELAY.
   localparam int             CW        = (BOOT_DELAY < 1) ? 1 : $clog2(BOOT_DELAY + 1);
   localparam logic [CW-1:0]  BOOT_LAST = CW'(BOOT_DELAY);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state;
   logic [CW-1:0]   boot_cnt;
   logic [XLEN-1:0] target;
   logic            target_misaligned;

   // Sequential fetch address; wraps modulo 2^XLEN.
   assign pc_plus4 = pc + XLEN'(4);

   // Next-PC select; JALR target always has bit 0 cleared before any further use.
   always_comb begin
      target = pc_plus4;
      case (pc_src)
         2'b00:   target = pc_plus4;
         2'b01:   target = branch_target;
         2'b10:   target = jal_target;
         default: target = jalr_target & ~XLEN'(1);
      endcase
      target_misaligned = (target[1:0] != 2'b00);
   end

`ifndef PC_MISALIGN_TRAP_EN
   // Without trapping, epc never moves and misalign never fires.
   assign misalign = 1'b0;
   assign epc      = RESET_VECTOR;
`endif

   // Boot/run state machine owning pc, fetch_valid and (with trapping) epc/misalign.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         boot_cnt    <= '0;
         pc          <= RESET_VECTOR;
         fetch_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         epc         <= RESET_VECTOR;
         misalign    <= 1'b0;
`endif
      end else begin
`ifdef PC_MISALIGN_TRAP_EN
         misalign <= 1'b0;
`endif
         case (state)
            BOOT: begin
               pc <= RESET_VECTOR;
               if (boot_cnt == BOOT_LAST) begin
                  state       <= RUN;
                  fetch_valid <= 1'b1;
               end else begin
                  boot_cnt <= boot_cnt + CW'(1);
               end
            end
            RUN: begin
               fetch_valid <= 1'b1;
               if (!stall) begin
                  if (trap_return) begin
                     pc <= epc;
                  end else begin
`ifdef PC_MISALIGN_TRAP_EN
                     if (target_misaligned) begin
                        pc       <= TRAP_VECTOR;
                        epc      <= pc;
                        misalign <= 1'b1;
                     end else begin
                        pc <= target;
                     end
`else
                     pc <= {target[XLEN-1:2], 2'b00};
`endif
                  end
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

`ifndef PC_MISALIGN_TRAP_EN
   // Misalignment flag only matters when trapping is built in.
   logic unused_misaligned;
   assign unused_misaligned = target_misaligned;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - randomized self-checking bench for pc_gen_unit against a behavioural model
module tb_pc_gen_unit;

   localparam int          XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] TV   = 32'h0000_0100;
   localparam int          BD   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jal_target;
   logic [31:0] jalr_target;
   logic        trap_return;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        misalign;
   logic [31:0] epc;

   always #5 clk = ~clk;

   pc_gen_unit #(
      .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_DELAY(BD)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
      .branch_target(branch_target), .jal_target(jal_target), .jalr_target(jalr_target),
      .trap_return(trap_return), .pc(pc), .pc_plus4(pc_plus4),
      .fetch_valid(fetch_valid), .misalign(misalign), .epc(epc)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: boot is tracked as edges elapsed since reset release.
   logic [31:0] m_pc, m_epc;
   logic        m_fv, m_mis;
   int          m_edges;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      if (rst) begin
         m_pc = RV; m_epc = RV; m_fv = 1'b0; m_mis = 1'b0; m_edges = 0;
      end else if (!m_fv) begin
         m_edges++;
         m_mis = 1'b0;
         if (m_edges == BD + 1) m_fv = 1'b1;
      end else begin
         m_mis = 1'b0;
         if (!stall) begin
            if (trap_return) begin
               m_pc = m_epc;
            end else begin
               case (pc_src)
                  2'd0: tgt = m_pc + 32'd4;
                  2'd1: tgt = branch_target;
                  2'd2: tgt = jal_target;
                  default: tgt = (jalr_target / 2) * 2;
               endcase
`ifdef PC_MISALIGN_TRAP_EN
               if (tgt % 4 != 0) begin
                  m_epc = m_pc; m_pc = TV; m_mis = 1'b1;
               end else begin
                  m_pc = tgt;
               end
`else
               m_pc = (tgt / 4) * 4;
`endif
            end
         end
      end
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
      check({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, m_fv});
      check({tag, ".mis"}, {31'd0, misalign}, {31'd0, m_mis});
      check({tag, ".epc"}, epc, m_epc);
   endtask

   task automatic drive(input logic s, input logic t, input logic [1:0] src,
                        input logic [31:0] b, input logic [31:0] j, input logic [31:0] r);
      stall = s; trap_return = t; pc_src = src;
      branch_target = b; jal_target = j; jalr_target = r;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 2'd0, 0, 0, 0);
      cycle("rst0");
      cycle("rst1");
      check("reset_fv", {31'd0, fetch_valid}, 32'd0);
      check("reset_pc", pc, RV);

      // Boot hold: pc_src is ignored while booting.
      rst = 1'b0;
      drive(0, 0, 2'd2, 0, 32'h0000_0800, 0);
      for (int i = 0; i < BD; i++) cycle("boot");
      check("boot_fv_low", {31'd0, fetch_valid}, 32'd0);
      cycle("boot_last");
      check("boot_fv_high", {31'd0, fetch_valid}, 32'd1);
      check("boot_pc", pc, RV);
      drive(0, 0, 2'd0, 0, 0, 0);
      cycle("first_seq");
      check("first_seq_pc", pc, RV + 32'd4);

      // Target select.
      drive(0, 0, 2'd2, 0, 32'h100, 0);           cycle("to100");
      drive(0, 0, 2'd1, 32'h200, 32'h300, 32'h401); cycle("br");
      drive(0, 0, 2'd2, 32'h200, 32'h300, 32'h401); cycle("jal");
      drive(0, 0, 2'd3, 32'h200, 32'h300, 32'h401); cycle("jalr");
      check("jalr_bit0", pc, 32'h400);

      // Stall holds pc; jump lands one edge after stall drops.
      drive(0, 0, 2'd2, 0, 32'h100, 0); cycle("back100");
      drive(1, 0, 2'd2, 0, 32'h800, 0);
      for (int i = 0; i < 3; i++) cycle("stall");
      check("stall_pc", pc, 32'h100);
      drive(0, 0, 2'd2, 0, 32'h800, 0); cycle("unstall");
      check("unstall_pc", pc, 32'h800);

      // Misaligned branch, then trap return.
      drive(0, 0, 2'd2, 0, 32'h40, 0);     cycle("to40");
      drive(0, 0, 2'd1, 32'h1002, 0, 0);   cycle("trap");
`ifdef PC_MISALIGN_TRAP_EN
      check("trap_pc", pc, TV);
      check("trap_epc", epc, 32'h40);
      check("trap_mis", {31'd0, misalign}, 32'd1);
`else
      check("notrap_pc", pc, 32'h1000);
      check("notrap_epc", epc, RV);
      check("notrap_mis", {31'd0, misalign}, 32'd0);
`endif
      drive(0, 0, 2'd0, 0, 0, 0);          cycle("post_trap");
      check("mis_pulse_end", {31'd0, misalign}, 32'd0);
      drive(0, 1, 2'd1, 32'h1002, 0, 0);   cycle("tret");

      // Stall together with a misaligned select: no trap.
      drive(1, 0, 2'd1, 32'h2006, 0, 0);   cycle("stall_mis");
      check("stall_mis_flag", {31'd0, misalign}, 32'd0);
      drive(0, 0, 2'd1, 32'h2006, 0, 0);   cycle("mis_after_stall");

      // Wrap of pc_plus4.
      drive(0, 0, 2'd2, 0, 32'hFFFF_FFFC, 0); cycle("to_top");
      check("top_pc4", pc_plus4, 32'h0);
      drive(0, 0, 2'd0, 0, 0, 0);          cycle("wrap");
      check("wrap_pc", pc, 32'h0);

      // Reset mid-run.
      drive(0, 0, 2'd2, 0, 32'h500, 0);    cycle("pre_rst");
      rst = 1'b1;                          cycle("mid_rst");
      check("mid_rst_fv", {31'd0, fetch_valid}, 32'd0);
      rst = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] lowmask;
         rst = ($urandom_range(0, 99) == 0);
         lowmask = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
         drive($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
               $urandom & lowmask, $urandom & lowmask, $urandom & (lowmask | 32'h1));
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
